// File: rtl/bus_pkg.sv
// Shared types and helpers for the memory-bus responder: FSM state, latched request, byte-mask expansion.
package bus_pkg;

  localparam int unsigned WORD_BYTES      = 4;
  localparam int unsigned MAX_WAIT_STATES = 15;
  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned MASK_W          = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rd;
    logic              wr;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] value;
  } bus_req_t;

  // Replicate each byte-enable bit across its 8-bit lane.
  function automatic logic [DATA_W-1:0] expand_mask(input logic [MASK_W-1:0] m);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < int'(MASK_W); i++) begin
      r[8*i +: 8] = {8{m[i]}};
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_ram_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The read register returns zero on cycles without a read; the storage itself is never reset.
module bus_ram_array
  import bus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [MASK_W-1:0] wr_be,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic [DATA_W-1:0] wr_bits_c;

  always_comb begin
    wr_bits_c = expand_mask(wr_be);
    rdata_d   = rd_en ? mem_q[addr] : '0;
  end

  // Merge only the enabled byte lanes into the stored word.
  always_ff @(posedge clk) begin
    if (|wr_be) begin
      mem_q[addr] <= (mem_q[addr] & ~wr_bits_c) | (wdata & wr_bits_c);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bus_ram_responder.sv
// Memory-bus target: latches a request, counts wait states, performs one RAM access and
// answers with a single-cycle ready pulse (plus fault when the address is outside the window).
module bus_ram_responder
  import bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_in,
  input  logic        read_in,
  input  logic        write_in,
  output logic [31:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic        ready_out,
  output logic        fault_out
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = $clog2(MAX_WAIT_STATES + 1);
  localparam logic [32:0] LIMIT = 33'(BASE_ADDR) + 33'(DEPTH_WORDS * WORD_BYTES);
  localparam logic [CNT_W-1:0] CNT_RELOAD = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
  localparam bit NO_WAIT = (WAIT_STATES == 0);

  resp_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  bus_req_t         req_q, req_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;

  bus_req_t         cur_req_c, acc_req_c;
  logic             req_c, req_changed_c, access_c;
  logic             acc_in_range_c;
  logic [IDX_W-1:0] acc_idx_c;
  logic             ram_rd_en_c;
  logic [3:0]       ram_be_c;
  logic [31:0]      ram_rdata;

  // The access uses the live bus in IDLE (zero wait states) and the latched request from WAIT.
  always_comb begin
    cur_req_c.addr  = address_in;
    cur_req_c.rd    = read_in;
    cur_req_c.wr    = write_in;
    cur_req_c.mask  = write_mask_in;
    cur_req_c.value = write_value_in;
    req_c           = read_in | write_in;
    req_changed_c   = (address_in != req_q.addr) || (read_in != req_q.rd) || (write_in != req_q.wr);
    acc_req_c       = (state_q == WAIT) ? req_q : cur_req_c;
    acc_in_range_c  = (acc_req_c.addr >= BASE_ADDR) && ({1'b0, acc_req_c.addr} < LIMIT);
    acc_idx_c       = IDX_W'((acc_req_c.addr - BASE_ADDR) >> 2);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    access_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_c) begin
          req_d = cur_req_c;
          if (NO_WAIT) begin
            access_c = 1'b1;
            state_d  = RESP;
          end else begin
            cnt_d   = CNT_RELOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req_c) begin
          state_d = IDLE;
        end else if (req_changed_c) begin
          req_d = cur_req_c;
          cnt_d = CNT_RELOAD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          access_c = 1'b1;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A reset edge must never commit a write.
    access_c    = access_c & ~reset;
    ready_d     = access_c;
    fault_d     = access_c & ~acc_in_range_c;
    ram_rd_en_c = access_c & acc_req_c.rd & acc_in_range_c;
    ram_be_c    = (access_c & acc_req_c.wr & acc_in_range_c) ? acc_req_c.mask : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end

  bus_ram_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .rd_en (ram_rd_en_c),
    .wr_be (ram_be_c),
    .addr  (acc_idx_c),
    .wdata (acc_req_c.value),
    .rdata (ram_rdata)
  );

  assign read_value_out = ram_rdata;
  assign ready_out      = ready_q;
  assign fault_out      = fault_q;

endmodule

// File: doc/bus_ram_responder.md
Name: bus_ram_responder

Overview:
- Responder (target) end of the common memory bus; sits downstream of the bus arbiter and serves its address/read/write/mask/value requests.
- Contains a word-organised on-chip RAM with byte-masked writes and a programmable number of wait states.
- Answers each request with a one-cycle ready pulse, plus a fault pulse when the address is outside the decoded window.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two, at least 2.
- WAIT_STATES, 1: extra cycles inserted before ready; range 0..15.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- address_in  in  32  byte address; bits [1:0] ignored
- read_in  in  1  read request
- write_in  in  1  write request; read_in and write_in are never both high
- read_value_out  out  32  read data; valid only while ready_out=1, otherwise 0
- write_mask_in  in  4  bit i enables byte lane [8i+7:8i]
- write_value_in  in  32  write data
- ready_out  out  1  request complete; single-cycle pulse, registered
- fault_out  out  1  pulses together with ready_out when the completed request was out of range

Behaviour:
- Reset values: ready_out=0, read_value_out=0, fault_out=0, state=IDLE, wait counter=0. RAM contents are not cleared.
- Reset mid-operation: return to IDLE. A pending request is dropped with no write and no ready.
- Request present: req = read_in | write_in.
- Latch: {address, read, write, mask, value} are captured on the accepting edge.
- States:
  - IDLE:
    - req=0: stay.
    - req=1 and WAIT_STATES=0: latch request, perform the access on this edge, go to RESP.
    - req=1 and WAIT_STATES>0: latch request, load cnt=WAIT_STATES-1, go to WAIT.
  - WAIT:
    - req=0: abort to IDLE; no write, no ready.
    - req=1 but address_in, read_in or write_in differs from the latch: re-latch, reload cnt=WAIT_STATES-1, stay in WAIT.
    - cnt>0: decrement.
    - cnt=0: perform the access on this edge, go to RESP.
  - RESP: ready_out=1 for exactly this cycle, then go to IDLE unconditionally. A request still high in the following IDLE cycle is treated as a new request.
- Latency: when a request is first sampled in IDLE at cycle 0, ready_out is high in cycle WAIT_STATES+1.
- Throughput: one access per WAIT_STATES+2 cycles.
- Address decode:
  - in range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS, compared as 32-bit unsigned, with BASE_ADDR + 4*DEPTH_WORDS computed 33 bits wide (no wrap).
  - word index = (addr - BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
- Access on the edge entering RESP:
  - Read, in range: read_value_out is registered from RAM[index].
  - Write, in range: RAM[index] byte lanes with mask=1 take write_value_in lanes; other lanes are unchanged. mask=0000 is a legal no-op that still completes with ready. read_value_out=0.
  - Out of range: no RAM change, read_value_out=0, fault_out=1 in the RESP cycle.
- Read-after-write: a read accepted after a write's RESP cycle returns the new data. No bypass is needed, because accesses are serialised.
- Outputs of a read are registered, so no combinational path runs from the bus inputs to read_value_out. ready_out is also registered.
- Mask, value and address changes while in RESP are ignored.

Decomposition:
- Package bus_pkg:
  - typedef enum for responder state {IDLE, WAIT, RESP}
  - typedef for the latched request struct
  - function expanding a 4-bit byte mask to a 32-bit bit mask
  - constants WORD_BYTES=4 and MAX_WAIT_STATES=15
- Sub-module bus_ram_array:
  - DEPTH_WORDS x 32 single-port synchronous RAM with per-byte write enable and registered read output
  - no reset on the storage
- The top level holds the FSM, address decode, counter and output registers.

Test Plan:
- WAIT_STATES=1, BASE_ADDR=0: write addr 0x10, value 0xDEADBEEF, mask 1111, held until ready -> ready high in cycle 2 for one cycle, fault 0. Then a read of 0x10 returns 0xDEADBEEF in its ready cycle.
- Byte mask: RAM[0x10]=0xDEADBEEF, write 0x11223344 with mask 0101 -> a read of 0x10 returns 0xDE22BE44. mask 0000 -> the word is unchanged and ready still pulses.
- Out of range: DEPTH_WORDS=1024, read 0x1000 -> ready and fault both pulse in cycle 2, read_value_out=0. A write to 0xFFFF_FFFC -> fault, and no RAM word changes (spot-check index 0 and 1023).
- Abort and restart, WAIT_STATES=3: deassert the request after one cycle -> no ready, no write. Then change the address from 0x20 to 0x24 in cycle 2 -> ready arrives 4 cycles after the change, and the access goes to 0x24.
- Back-to-back, WAIT_STATES=0: hold the read of 0x0 continuously -> ready pulses in cycles 1, 3, 5, never on consecutive cycles.
- Reset: assert reset during WAIT of a write to 0x30 -> ready/fault/read_value are 0 next cycle, state is IDLE, and RAM[0x30] keeps its prior value.
